// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - SYNC/LEN/payload/CSUM frame receiver fed from a first-word fall-through byte FIFO
module uart_frame_rx #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 64,
  parameter int         TO_CYC  = 100000,
  parameter int         TO_BIT  = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic [7:0] pay_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_BIT-1:0] TO_LAST   = TO_BIT'(TO_CYC - 1);
  localparam logic [TO_BIT-1:0] TO_ONE    = TO_BIT'(1);
  localparam logic [1:0]        ERR_LEN   = 2'd1;
  localparam logic [1:0]        ERR_CSUM  = 2'd2;
  localparam logic [1:0]        ERR_TO    = 2'd3;

  typedef enum logic [1:0] {IDLE, LEN, PAY, CSUM} state_t;

  state_t            state;
  logic [7:0]        frame_len;
  logic [7:0]        sum;
  logic [7:0]        cnt;
  logic [TO_BIT-1:0] to_cnt;
  logic              pop;
  logic              timeout_hit;
  logic [7:0]        sum_next;

  // Every byte the FIFO presents is consumed in the same cycle; reset blocks the pop.
  assign rd_uart     = ~rx_empty & ~reset;
  assign pop         = rd_uart;
  assign sum_next    = sum + r_data;
  // The idle cycle that would bring the counter to TO_CYC aborts the frame; a pop that cycle wins.
  assign timeout_hit = (state != IDLE) && !pop && (to_cnt == TO_LAST);

  // Frame parser FSM with registered payload, status pulses and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame_len  <= 8'd0;
      sum        <= 8'd0;
      cnt        <= 8'd0;
      to_cnt     <= '0;
      pay_data   <= 8'd0;
      pay_idx    <= 8'd0;
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      pay_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || pop) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_ONE;
      end

      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TO;
        state     <= IDLE;
        to_cnt    <= '0;
      end else if (pop) begin
        case (state)
          IDLE: begin
            if (r_data == SYNC) begin
              state <= LEN;
            end
          end
          LEN: begin
            if (r_data == 8'd0 || r_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
            end else begin
              frame_len <= r_data;
              sum       <= r_data;
              cnt       <= 8'd0;
              state     <= PAY;
            end
          end
          PAY: begin
            sum       <= sum_next;
            pay_data  <= r_data;
            pay_idx   <= cnt;
            pay_valid <= 1'b1;
            cnt       <= cnt + 8'd1;
            if (cnt == frame_len - 8'd1) begin
              state <= CSUM;
            end
          end
          CSUM: begin
            if (sum_next == 8'd0) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - randomized scoreboard bench for uart_frame_rx
module tb_uart_frame_rx;

  localparam int MAX_LEN = 64;
  localparam int TO_CYC  = 50;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data   = 8'd0;
  logic       rd_uart;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic [7:0] pay_idx;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // kind: 0 = payload byte, 1 = frame_done, 2 = frame_err; at = cycle the output must be visible
  typedef struct {
    int kind;
    int idx;
    int data;
    int code;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  model_code = 0;

  uart_frame_rx #(
    .SYNC    (8'hA5),
    .MAX_LEN (MAX_LEN),
    .TO_CYC  (TO_CYC),
    .TO_BIT  (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .pay_data   (pay_data),
    .pay_valid  (pay_valid),
    .pay_idx    (pay_idx),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic exp_ev(input int kind, input int idx, input int data, input int code, input int at);
    ev_t e;
    if (kind == 2) model_code = code;
    e.kind = kind;
    e.idx  = idx;
    e.data = data;
    e.code = model_code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind);
    ev_t e;
    int  a_idx;
    int  a_data;
    checks++;
    a_idx  = (kind == 0) ? int'(pay_idx) : 0;
    a_data = (kind == 0) ? int'(pay_data) : 0;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_output kind=%0d idx=%0d data=%02h code=%0d cyc=%0d expected=none",
               kind, a_idx, a_data, err_code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || e.idx != a_idx || e.data != a_data || e.code != int'(err_code)) begin
        failures++;
        $display("FAIL event got kind=%0d idx=%0d data=%02h code=%0d cyc=%0d expected kind=%0d idx=%0d data=%02h code=%0d cyc=%0d",
                 kind, a_idx, a_data, err_code, cyc, e.kind, e.idx, e.data, e.code, e.at);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, independent of the stimulus process.
  always @(negedge clk) begin
    chk("rd_uart", {31'd0, rd_uart}, {31'd0, ~rx_empty & ~reset});
    if (frame_done && frame_err) chk("done_err_overlap", 1, 0);
    if (pay_valid === 1'b1)  check_ev(0);
    if (frame_done === 1'b1) check_ev(1);
    if (frame_err === 1'b1)  check_ev(2);
  end

  task automatic idle(input int n);
    rx_empty = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int b, input int gap, output int pc);
    idle(gap);
    r_data   = 8'(b);
    rx_empty = 1'b0;
    pc       = cyc;
    @(posedge clk);
    #1;
    rx_empty = 1'b1;
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 19) return $urandom_range(1, 3);
    return TO_CYC - 1;
  endfunction

  task automatic good_frame(input int n, input bit bad);
    int pc;
    int s;
    int b;
    int cs;
    send(8'hA5, $urandom_range(0, 3), pc);
    send(n, rgap(), pc);
    s = n;
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 255);
      send(b, rgap(), pc);
      exp_ev(0, i, b, 0, pc + 1);
      s += b;
    end
    cs = (256 - (s % 256)) % 256;
    if (bad) cs = (cs + $urandom_range(1, 255)) % 256;
    send(cs, rgap(), pc);
    if (bad) exp_ev(2, 0, 0, 2, pc + 1);
    else     exp_ev(1, 0, 0, 0, pc + 1);
  endtask

  task automatic bad_len_frame();
    int pc;
    int l;
    l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
    send(8'hA5, $urandom_range(0, 3), pc);
    send(l, rgap(), pc);
    exp_ev(2, 0, 0, 1, pc + 1);
  endtask

  task automatic garbage(input int n);
    int pc;
    int b;
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 255);
      if (b == 8'hA5) b = 8'h5A;
      send(b, $urandom_range(0, 2), pc);
    end
  endtask

  // Stalls after k bytes following SYNC: k=0 in LEN, 1..n in PAY, n+1 in CSUM.
  task automatic timeout_frame(input int n);
    int pc;
    int k;
    int b;
    k = $urandom_range(0, n + 1);
    send(8'hA5, 0, pc);
    if (k >= 1) send(n, rgap(), pc);
    for (int i = 0; i < k - 1; i++) begin
      b = $urandom_range(0, 255);
      send(b, rgap(), pc);
      exp_ev(0, i, b, 0, pc + 1);
    end
    exp_ev(2, 0, 0, 3, pc + TO_CYC + 1);
    idle(TO_CYC + $urandom_range(0, 3));
  endtask

  initial begin
    int pc;
    int t;

    reset    = 1'b1;
    rx_empty = 1'b0;
    r_data   = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_uart", {31'd0, rd_uart}, 0);
    chk("reset_pay_valid", {31'd0, pay_valid}, 0);
    chk("reset_frame_done", {31'd0, frame_done}, 0);
    chk("reset_frame_err", {31'd0, frame_err}, 0);
    chk("reset_pay_data", {24'd0, pay_data}, 0);
    chk("reset_pay_idx", {24'd0, pay_idx}, 0);
    chk("reset_err_code", {30'd0, err_code}, 0);
    rx_empty = 1'b1;
    reset    = 1'b0;
    idle(2);

    // Good frame A5 03 11 22 33 97
    send(8'hA5, 0, pc); send(8'h03, 0, pc);
    send(8'h11, 0, pc); exp_ev(0, 0, 8'h11, 0, pc + 1);
    send(8'h22, 0, pc); exp_ev(0, 1, 8'h22, 0, pc + 1);
    send(8'h33, 0, pc); exp_ev(0, 2, 8'h33, 0, pc + 1);
    send(8'h97, 0, pc); exp_ev(1, 0, 0, 0, pc + 1);

    // Bad checksum A5 03 11 22 33 98, SYNC accepted immediately after the previous frame
    send(8'hA5, 0, pc); send(8'h03, 0, pc);
    send(8'h11, 0, pc); exp_ev(0, 0, 8'h11, 0, pc + 1);
    send(8'h22, 0, pc); exp_ev(0, 1, 8'h22, 0, pc + 1);
    send(8'h33, 0, pc); exp_ev(0, 2, 8'h33, 0, pc + 1);
    send(8'h98, 0, pc); exp_ev(2, 0, 0, 2, pc + 1);

    // Illegal lengths 00 and 41
    send(8'hA5, 0, pc); send(8'h00, 0, pc); exp_ev(2, 0, 0, 1, pc + 1);
    send(8'hA5, 0, pc); send(8'h41, 0, pc); exp_ev(2, 0, 0, 1, pc + 1);

    // Garbage hunt then A5 01 7E 81
    send(8'h00, 0, pc); send(8'hFF, 0, pc); send(8'h5A, 0, pc);
    send(8'hA5, 0, pc); send(8'h01, 0, pc);
    send(8'h7E, 0, pc); exp_ev(0, 0, 8'h7E, 1, pc + 1);
    send(8'h81, 0, pc); exp_ev(1, 0, 0, 1, pc + 1);

    // SYNC value inside the frame is plain data
    send(8'hA5, 0, pc); send(8'h02, 0, pc);
    send(8'hA5, 0, pc); exp_ev(0, 0, 8'hA5, 1, pc + 1);
    send(8'hA5, 0, pc); exp_ev(0, 1, 8'hA5, 1, pc + 1);
    send(8'hB4, 0, pc); exp_ev(1, 0, 0, 1, pc + 1);

    // Timeout: A5 04 01 02 then empty FIFO
    send(8'hA5, 0, pc); send(8'h04, 0, pc);
    send(8'h01, 0, pc); exp_ev(0, 0, 8'h01, 1, pc + 1);
    send(8'h02, 0, pc); exp_ev(0, 1, 8'h02, 1, pc + 1);
    exp_ev(2, 0, 0, 3, pc + TO_CYC + 1);
    idle(TO_CYC + 3);

    // A byte on the 50th idle cycle suppresses the timeout
    send(8'hA5, 0, pc); send(8'h04, 0, pc);
    send(8'h01, 0, pc); exp_ev(0, 0, 8'h01, 3, pc + 1);
    send(8'h02, 0, pc); exp_ev(0, 1, 8'h02, 3, pc + 1);
    send(8'h03, TO_CYC - 1, pc); exp_ev(0, 2, 8'h03, 3, pc + 1);
    send(8'h04, 0, pc); exp_ev(0, 3, 8'h04, 3, pc + 1);
    send(8'hF2, 0, pc); exp_ev(1, 0, 0, 3, pc + 1);

    // Reset mid-frame: A5 03 11, reset, 22 33 A5 01 05 FA
    send(8'hA5, 0, pc); send(8'h03, 0, pc);
    send(8'h11, 0, pc); exp_ev(0, 0, 8'h11, 3, pc + 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    model_code = 0;
    send(8'h22, 0, pc); send(8'h33, 0, pc);
    send(8'hA5, 0, pc); send(8'h01, 0, pc);
    send(8'h05, 0, pc); exp_ev(0, 0, 8'h05, 0, pc + 1);
    send(8'hFA, 0, pc); exp_ev(1, 0, 0, 0, pc + 1);

    // Largest legal length
    good_frame(MAX_LEN, 1'b0);

    for (int f = 0; f < 40; f++) begin
      t = $urandom_range(0, 4);
      case (t)
        0:       good_frame($urandom_range(1, MAX_LEN), 1'b0);
        1:       good_frame($urandom_range(1, 8), 1'b1);
        2:       bad_len_frame();
        3:       garbage($urandom_range(1, 4));
        default: timeout_frame($urandom_range(1, 6));
      endcase
    end

    idle(TO_CYC + 10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
